// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm: whack-a-button round controller placed upstream of the servo
// countdown timer. Conditions the five raw buttons (2-flop sync + debounce +
// rising-edge pulse), picks targets with an 8-bit LFSR, runs the round FSM and
// drives timer_run / win / lose indication.
// Optional build macro: GAME_CTRL_PENALTY_EN -- a wrong press in PLAY takes one
// point off the score (saturating at 0); without it wrong presses are ignored.
module game_ctrl_fsm #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         WIN_SCORE       = 10,
    parameter int         RESULT_HOLD     = 150000000,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic [3:0] btn,
    input  logic       time_up,
    output logic       timer_run,
    output logic [3:0] target_led,
    output logic [3:0] score,
    output logic       win_led,
    output logic       lose_led,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_WIN  = 3'd3,
        ST_LOSE = 3'd4
    } state_t;

    localparam int             DBW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int             HLW        = $clog2(RESULT_HOLD + 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HLW-1:0] HOLD_LAST  = HLW'(RESULT_HOLD - 1);
    localparam logic [3:0]     SCORE_LAST = 4'(WIN_SCORE - 1);
    localparam logic [3:0]     SCORE_WIN  = 4'(WIN_SCORE);

    // Next value of the Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Bit 4 is the start button, bits 3:0 the game buttons.
    logic [4:0]     raw_s;
    logic [4:0]     sync1_r;
    logic [4:0]     sync2_r;
    logic [4:0]     deb_r;
    logic [4:0]     deb_d_r;
    logic [4:0]     pulse_r;
    logic [DBW-1:0] db_cnt_r [5];

    logic [7:0]     lfsr_r;
    logic [3:0]     cand_s;
    logic [3:0]     new_target_s;
    logic [3:0]     game_pulse_s;
    logic           start_pulse_s;

    state_t         state_r;
    logic           timer_run_r;
    logic [3:0]     target_led_r;
    logic [3:0]     score_r;
    logic           win_led_r;
    logic           lose_led_r;
    logic [HLW-1:0] hold_cnt_r;

    assign raw_s         = {btn_start, btn};
    assign game_pulse_s  = pulse_r[3:0];
    assign start_pulse_s = pulse_r[4];

    // Synchronize, debounce and edge-detect all five buttons; a level is
    // accepted only after it has differed from the debounced value for
    // DEBOUNCE_CYCLES consecutive cycles, and only presses make a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 5'b0;
            sync2_r <= 5'b0;
            deb_r   <= 5'b0;
            deb_d_r <= 5'b0;
            pulse_r <= 5'b0;
            for (int i = 0; i < 5; i++) begin
                db_cnt_r[i] <= DBW'(0);
            end
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            deb_d_r <= deb_r;
            pulse_r <= deb_r & ~deb_d_r;
            for (int i = 0; i < 5; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST) begin
                        deb_r[i]    <= sync2_r[i];
                        db_cnt_r[i] <= DBW'(0);
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + DBW'(1);
                    end
                end else begin
                    db_cnt_r[i] <= DBW'(0);
                end
            end
        end
    end

    // Free-running target LFSR, advancing every clock out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    // Candidate target from the LFSR, rotated so it never repeats the lit one.
    always_comb begin
        cand_s = 4'b0001 << lfsr_r[1:0];
        if (cand_s == target_led_r) begin
            new_target_s = {cand_s[2:0], cand_s[3]};
        end else begin
            new_target_s = cand_s;
        end
    end

    // Round FSM with registered outputs; time_up is only looked at in PLAY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            timer_run_r  <= 1'b0;
            target_led_r <= 4'b0;
            score_r      <= 4'b0;
            win_led_r    <= 1'b0;
            lose_led_r   <= 1'b0;
            hold_cnt_r   <= HLW'(0);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    timer_run_r  <= 1'b0;
                    target_led_r <= 4'b0;
                    win_led_r    <= 1'b0;
                    lose_led_r   <= 1'b0;
                    hold_cnt_r   <= HLW'(0);
                    if (start_pulse_s) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    score_r      <= 4'b0;
                    target_led_r <= new_target_s;
                    timer_run_r  <= 1'b1;
                    state_r      <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (time_up) begin
                        state_r      <= ST_LOSE;
                        timer_run_r  <= 1'b0;
                        target_led_r <= 4'b0;
                        lose_led_r   <= 1'b1;
                        hold_cnt_r   <= HLW'(0);
                    end else if ((game_pulse_s != 4'b0) && (game_pulse_s == target_led_r)) begin
                        if (score_r == SCORE_LAST) begin
                            score_r      <= SCORE_WIN;
                            state_r      <= ST_WIN;
                            timer_run_r  <= 1'b0;
                            target_led_r <= 4'b0;
                            win_led_r    <= 1'b1;
                            hold_cnt_r   <= HLW'(0);
                        end else begin
                            score_r      <= score_r + 4'd1;
                            target_led_r <= new_target_s;
                        end
                    end else if (game_pulse_s != 4'b0) begin
`ifdef GAME_CTRL_PENALTY_EN
                        if (score_r != 4'd0) begin
                            score_r <= score_r - 4'd1;
                        end else begin
                            score_r <= 4'd0;
                        end
`else
                        score_r <= score_r;
`endif
                    end else begin
                        state_r <= ST_PLAY;
                    end
                end
                ST_WIN, ST_LOSE: begin
                    timer_run_r  <= 1'b0;
                    target_led_r <= 4'b0;
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r    <= ST_IDLE;
                        win_led_r  <= 1'b0;
                        lose_led_r <= 1'b0;
                        hold_cnt_r <= HLW'(0);
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HLW'(1);
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    timer_run_r  <= 1'b0;
                    target_led_r <= 4'b0;
                    win_led_r    <= 1'b0;
                    lose_led_r   <= 1'b0;
                    hold_cnt_r   <= HLW'(0);
                end
            endcase
        end
    end

    assign timer_run  = timer_run_r;
    assign target_led = target_led_r;
    assign score      = score_r;
    assign win_led    = win_led_r;
    assign lose_led   = lose_led_r;
    assign state_o    = state_r;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// tb_game_ctrl_fsm: scenario tasks plus a randomized round player checked
// against an abstract score/state model of the game rules.
module tb_game_ctrl_fsm;

    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int WS   = 3;

    localparam logic [2:0] M_IDLE = 3'd0;
    localparam logic [2:0] M_LOAD = 3'd1;
    localparam logic [2:0] M_PLAY = 3'd2;
    localparam logic [2:0] M_WIN  = 3'd3;
    localparam logic [2:0] M_LOSE = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b0;
    logic [3:0] btn = 4'b0;
    logic       time_up = 1'b0;
    logic       timer_run;
    logic [3:0] target_led;
    logic [3:0] score;
    logic       win_led;
    logic       lose_led;
    logic [2:0] state_o;

    int checks = 0;
    int passed = 0;

    game_ctrl_fsm #(
        .DEBOUNCE_CYCLES(DB),
        .WIN_SCORE(WS),
        .RESULT_HOLD(HOLD),
        .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_start(btn_start),
        .btn(btn),
        .time_up(time_up),
        .timer_run(timer_run),
        .target_led(target_led),
        .score(score),
        .win_led(win_led),
        .lose_led(lose_led),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise the given buttons for 'hold' cycles then release; observe the
    // outputs right after the clock edge on which the FSM reacts to the pulse.
    task automatic do_press(input logic st, input logic [3:0] mask, input int hold, input logic tu,
                            output logic [2:0] st_obs, output logic [3:0] sc_obs,
                            output logic [3:0] tg_obs, output logic tr_obs);
        for (int c = 0; c < hold + 12; c++) begin
            btn_start = (c < hold) ? st : 1'b0;
            btn       = (c < hold) ? mask : 4'b0;
            time_up   = tu && (c >= 7) && (c <= 9);
            @(negedge clk);
            if (c == 7) begin
                st_obs = state_o; sc_obs = score; tg_obs = target_led; tr_obs = timer_run;
            end
        end
        time_up = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycles(3);
        checks++; if (state_o !== M_IDLE) $display("FAIL reset_state: got %0d want 0", state_o); else passed++;
        checks++; if (timer_run !== 1'b0) $display("FAIL reset_timer_run: got %b want 0", timer_run); else passed++;
        rst_n = 1'b1;
        cycles(2);
        checks++; if (target_led !== 4'b0) $display("FAIL reset_target: got %h want 0", target_led); else passed++;
        checks++; if (score !== 4'd0) $display("FAIL reset_score: got %0d want 0", score); else passed++;
        checks++; if ({win_led, lose_led} !== 2'b00) $display("FAIL reset_leds: got %b want 00", {win_led, lose_led}); else passed++;
        checks++; if ({state_o, timer_run} !== 4'b0) $display("FAIL reset_after_release: got %b want 0000", {state_o, timer_run}); else passed++;
    endtask

    task automatic test_start();
        for (int c = 0; c < 20; c++) begin
            btn_start = (c < 10);
            @(negedge clk);
            if (c == 6) begin
                checks++; if (state_o !== M_IDLE) $display("FAIL start_early: got %0d want 0", state_o); else passed++;
            end
            if (c == 7) begin
                checks++; if (state_o !== M_LOAD) $display("FAIL start_load: got %0d want 1", state_o); else passed++;
            end
            if (c == 8) begin
                checks++; if (state_o !== M_PLAY) $display("FAIL start_play: got %0d want 2", state_o); else passed++;
                checks++; if (timer_run !== 1'b1) $display("FAIL start_timer_run: got %b want 1", timer_run); else passed++;
                checks++; if ($countones(target_led) != 1) $display("FAIL start_onehot: got %h want one-hot", target_led); else passed++;
                checks++; if (score !== 4'd0) $display("FAIL start_score: got %0d want 0", score); else passed++;
            end
        end
        checks++; if (state_o !== M_PLAY) $display("FAIL start_release: got %0d want 2", state_o); else passed++;
    endtask

    task automatic test_win();
        logic [2:0] so; logic [3:0] sc, tg, prev; logic tr;
        for (int k = 1; k <= WS; k++) begin
            prev = target_led;
            do_press(1'b0, prev, 8, 1'b0, so, sc, tg, tr);
            if (k < WS) begin
                checks++; if (sc !== 4'(k)) $display("FAIL win_score: got %0d want %0d", sc, k); else passed++;
                checks++; if (($countones(tg) != 1) || (tg === prev)) $display("FAIL win_new_target: got %h prev %h want new one-hot", tg, prev); else passed++;
            end else begin
                checks++; if ({so, sc, tr, tg} !== {M_WIN, 4'(WS), 1'b0, 4'b0}) $display("FAIL win_enter: got st=%0d sc=%0d tr=%b tg=%h want st=3 sc=%0d tr=0 tg=0", so, sc, tr, tg, WS); else passed++;
            end
        end
        checks++; if (win_led !== 1'b1) $display("FAIL win_led: got %b want 1", win_led); else passed++;
        cycles(7);
        checks++; if (state_o !== M_WIN) $display("FAIL win_hold: got %0d want 3", state_o); else passed++;
        cycles(1);
        checks++; if ({state_o, win_led, score} !== {M_IDLE, 1'b0, 4'(WS)}) $display("FAIL win_to_idle: got st=%0d win=%b sc=%0d want 0 0 %0d", state_o, win_led, score, WS); else passed++;
    endtask

    task automatic test_bounce();
        logic [2:0] so; logic [3:0] sc, tg, mask; logic tr;
        do_press(1'b1, 4'b0, 8, 1'b0, so, sc, tg, tr);
        checks++; if ({state_o, score} !== {M_PLAY, 4'd0}) $display("FAIL bounce_setup: got st=%0d sc=%0d want 2 0", state_o, score); else passed++;
        mask = target_led;
        for (int c = 0; c < 24; c++) begin
            btn = (c >= 12 || (c % 4) < 2) ? mask : 4'b0;
            @(negedge clk);
            if (c == 18) begin
                checks++; if (score !== 4'd0) $display("FAIL bounce_early: got %0d want 0", score); else passed++;
            end
            if (c == 19) begin
                checks++; if (score !== 4'd1) $display("FAIL bounce_hit: got %0d want 1", score); else passed++;
            end
        end
        btn = 4'b0;
        cycles(12);
        checks++; if (score !== 4'd1) $display("FAIL bounce_single: got %0d want 1", score); else passed++;
    endtask

    task automatic test_race();
        logic [2:0] so; logic [3:0] sc, tg; logic tr;
        do_press(1'b0, target_led, 8, 1'b0, so, sc, tg, tr);
        checks++; if (sc !== 4'd2) $display("FAIL race_setup: got %0d want 2", sc); else passed++;
        do_press(1'b0, target_led, 8, 1'b1, so, sc, tg, tr);
        checks++; if ({so, sc, tr, tg} !== {M_LOSE, 4'd2, 1'b0, 4'b0}) $display("FAIL race_lose: got st=%0d sc=%0d tr=%b tg=%h want 4 2 0 0", so, sc, tr, tg); else passed++;
        checks++; if ({state_o, lose_led, win_led} !== {M_LOSE, 2'b10}) $display("FAIL race_leds: got st=%0d lose=%b win=%b want 4 1 0", state_o, lose_led, win_led); else passed++;
        cycles(7);
        checks++; if (state_o !== M_LOSE) $display("FAIL race_hold: got %0d want 4", state_o); else passed++;
        cycles(1);
        checks++; if ({state_o, lose_led, score} !== {M_IDLE, 1'b0, 4'd2}) $display("FAIL race_to_idle: got st=%0d lose=%b sc=%0d want 0 0 2", state_o, lose_led, score); else passed++;
    endtask

    task automatic test_wrong();
        logic [2:0] so; logic [3:0] sc, tg, prev, wrong, exp_sc; logic tr;
        do_press(1'b1, 4'b0, 8, 1'b0, so, sc, tg, tr);
        do_press(1'b0, target_led, 8, 1'b0, so, sc, tg, tr);
        checks++; if (sc !== 4'd1) $display("FAIL wrong_setup: got %0d want 1", sc); else passed++;
        for (int k = 0; k < 2; k++) begin
            prev  = target_led;
            wrong = {prev[2:0], prev[3]};
`ifdef GAME_CTRL_PENALTY_EN
            exp_sc = 4'd0;
`else
            exp_sc = 4'd1;
`endif
            do_press(1'b0, wrong, 8, 1'b0, so, sc, tg, tr);
            checks++; if ({so, sc, tg} !== {M_PLAY, exp_sc, prev}) $display("FAIL wrong_press: got st=%0d sc=%0d tg=%h want 2 %0d %h", so, sc, tg, exp_sc, prev); else passed++;
        end
        do_press(1'b0, 4'b0, 4, 1'b1, so, sc, tg, tr);
        cycles(HOLD);
        checks++; if (state_o !== M_IDLE) $display("FAIL wrong_exit: got %0d want 0", state_o); else passed++;
    endtask

    task automatic test_random();
        logic [2:0] so, m_state; logic [3:0] sc, tg, prev, mask, m_score; logic tr, tu;
        int r, hold;
        for (int rnd = 0; rnd < 6; rnd++) begin
            cycles($urandom_range(0, 15));
            do_press(1'b1, 4'b0, $urandom_range(4, 10), 1'b0, so, sc, tg, tr);
            m_state = M_PLAY; m_score = 4'd0;
            checks++; if ({state_o, score} !== {m_state, m_score}) $display("FAIL rand_start: got st=%0d sc=%0d want 2 0", state_o, score); else passed++;
            for (int ev = 0; ev < 14; ev++) begin
                prev = target_led;
                r    = $urandom_range(0, 9);
                hold = $urandom_range(4, 10);
                tu   = (r == 0) || (ev == 13);
                if (r == 0) mask = ($urandom_range(0, 1) == 1) ? prev : 4'b0;
                else if (r <= 3) begin
                    mask = 4'($urandom_range(1, 15));
                    while (mask == prev) mask = 4'($urandom_range(1, 15));
                end else mask = prev;
                do_press(1'b0, mask, hold, tu, so, sc, tg, tr);
                if (tu) m_state = M_LOSE;
                else if (mask == prev) begin
                    if (int'(m_score) == WS - 1) begin m_score = 4'(WS); m_state = M_WIN; end
                    else m_score = m_score + 4'd1;
                end else if (mask != 4'b0) begin
`ifdef GAME_CTRL_PENALTY_EN
                    if (m_score != 4'd0) m_score = m_score - 4'd1;
`endif
                end
                checks++; if ({so, sc} !== {m_state, m_score}) $display("FAIL rand_event: got st=%0d sc=%0d want %0d %0d (mask %h tu %b)", so, sc, m_state, m_score, mask, tu); else passed++;
                if (m_state == M_PLAY && mask == prev) begin
                    checks++; if (($countones(tg) != 1) || (tg === prev)) $display("FAIL rand_target: got %h prev %h", tg, prev); else passed++;
                end else if (m_state == M_PLAY) begin
                    checks++; if (tg !== prev) $display("FAIL rand_target_kept: got %h want %h", tg, prev); else passed++;
                end else begin
                    checks++; if ({tr, tg} !== 5'b0) $display("FAIL rand_end_outputs: got tr=%b tg=%h want 0 0", tr, tg); else passed++;
                    cycles(28 - (hold + 12));
                    checks++; if ({state_o, score} !== {M_IDLE, m_score}) $display("FAIL rand_idle: got st=%0d sc=%0d want 0 %0d", state_o, score, m_score); else passed++;
                    break;
                end
            end
        end
    endtask

    task automatic test_midreset();
        logic [2:0] so; logic [3:0] sc, tg; logic tr;
        do_press(1'b1, 4'b0, 8, 1'b0, so, sc, tg, tr);
        do_press(1'b0, target_led, 8, 1'b0, so, sc, tg, tr);
        cycles(3);
        rst_n = 1'b0;
        #1;
        checks++; if ({state_o, timer_run, score, target_led} !== 12'b0) $display("FAIL midreset: got st=%0d tr=%b sc=%0d tg=%h want all 0", state_o, timer_run, score, target_led); else passed++;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
    endtask

    initial begin
        test_reset();
        test_start();
        test_win();
        test_bounce();
        test_race();
        test_wrong();
        test_random();
        test_midreset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
